// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART byte receiver.
//
// Synchronises the raw serial pin and derives 16x oversample ticks from the
// system clock. It validates the start bit at its midpoint, samples 8 data bits
// (LSB first) at mid-bit, and checks the stop bit. Each good byte goes into a
// single-entry valid/ready holding register.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous active-low reset
//   irx        in   asynchronous serial line, idle high
//   rx_enable  in   receiver enable; low forces and holds IDLE
//   data_out   out  received byte, valid while data_valid=1
//   data_valid out  holding register full
//   data_ready in   consumer accepts byte when data_valid & data_ready
//   frame_err  out  one-cycle pulse: stop bit sampled 0
//   overrun    out  one-cycle pulse: good byte dropped, holding register full
//   busy       out  high whenever the FSM is not IDLE

module uart_rx_ctrl #(
    parameter int unsigned CLK_DIV = 27,
    parameter int unsigned DIV_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irx,
    input  logic       rx_enable,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [DIV_W-1:0] DivMax = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, rx_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [3:0]       samp_q, samp_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             pop, load;

    // The divider is parked at 0 in IDLE, so the first tick of a frame lands
    // CLK_DIV clocks after START is entered.
    assign tick  = (div_q == DivMax);
    assign div_d = (state_q == StIdle || tick) ? '0 : div_q + DIV_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!rx_enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (!rx_s_q) state_d = StStart;
                // Mid start bit: a high line here means the low was a glitch.
                StStart: if (tick && samp_q == 4'd7) state_d = rx_s_q ? StIdle : StData;
                StData:  if (tick && samp_q == 4'd15 && bit_idx_q == 3'd7) state_d = StStop;
                StStop:  if (tick && samp_q == 4'd15) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output and datapath next-state logic
    always_comb begin
        busy        = (state_q != StIdle);
        samp_d      = samp_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        pop         = valid_q & data_ready;
        load        = 1'b0;

        if (!rx_enable) begin
            // Abort: drop the partial byte, raise no flags.
            samp_d    = '0;
            bit_idx_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    samp_d    = '0;
                    bit_idx_d = '0;
                end
                StStart: begin
                    if (tick) begin
                        samp_d = (samp_q == 4'd7) ? 4'd0 : samp_q + 4'd1;
                    end
                end
                StData: begin
                    if (tick) begin
                        // 4-bit wrap clears the counter at each sample point,
                        // including the hand-off into STOP.
                        samp_d = samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            shift_d   = {rx_s_q, shift_q[7:1]};
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        samp_d = samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            if (!rx_s_q) begin
                                frame_err_d = 1'b1;
                            end else if (!valid_q || pop) begin
                                load = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    samp_d = '0;
                end
            endcase
        end

        data_d  = load ? shift_q : data_q;
        valid_d = load ? 1'b1 : (pop ? 1'b0 : valid_q);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            div_q       <= '0;
            samp_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= irx;
            rx_s_q      <= sync1_q;
            div_q       <= div_d;
            samp_q      <= samp_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller for the UART byte receiver.
- Generates 16x oversample ticks from the system clock and sequences start-bit validation, mid-bit sampling of 8 data bits (LSB first) and stop-bit checking.
- Presents each received byte through a single-entry valid/ready holding register.
- Flags framing errors and overruns; sits between the raw irx pin and the byte consumer (FIFO/CPU bus).

Parameters:
- CLK_DIV, 27, system clocks per oversample tick (27 ≈ 50 MHz / (115200 × 16)); minimum 2.
- DIV_W, 16, width of the tick divider counter; must satisfy 2^DIV_W > CLK_DIV.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- irx  input  1  asynchronous serial line, idle high.
- rx_enable  input  1  receiver enable; low forces and holds IDLE.
- data_out  output  8  received byte, valid while data_valid=1.
- data_valid  output  1  holding register full.
- data_ready  input  1  consumer accepts byte when data_valid & data_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: good byte dropped, holding register full.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State IDLE; divider, sample and bit counters 0.
  - Both sync flops 1.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame discards the partial byte.
- Sync:
  - irx passes through 2 flops; all decisions use the 2nd flop (rx_s).
  - Latency from pin to rx_s is 2 clks.
- Tick divider:
  - Held 0 in IDLE.
  - Otherwise counts 0..CLK_DIV-1 and wraps; tick=1 on the wrap cycle.
- States:
  - IDLE: if rx_enable & rx_s==0, go to START and clear the sample counter.
  - START: increment the sample counter on each tick. On the 8th tick (count 7, mid start bit):
    - rx_s==0: go to DATA, sample counter=0, bit index=0.
    - rx_s==1: glitch; go to IDLE, no flags.
  - DATA: on the 16th tick after the previous sample point, shift rx_s into bit[bit index] (LSB first) and increment bit index. After bit 7, go to STOP with the sample counter cleared.
  - STOP: on the 16th tick, sample rx_s and go to IDLE the same cycle (next start can be detected from the mid-stop-bit point on).
    - rx_s==1: good byte; perform the delivery check.
    - rx_s==0: frame_err=1 for one cycle; byte discarded; data_valid and data_out unchanged.
- Delivery at the good stop-sample cycle:
  - If data_valid==0, or (data_valid & data_ready) in that same cycle: data_out←byte, data_valid=1 next cycle. A simultaneous pop and load keeps data_valid=1 with the new byte.
  - Else: byte dropped, overrun=1 for one cycle, data_out keeps the old byte.
- Pop: data_valid & data_ready with no simultaneous load clears data_valid next cycle. data_out holds its value.
- Latency: data_valid rises 1 clk after the stop-bit sample tick.
- rx_enable=0 in any non-IDLE state aborts to IDLE next cycle. No output, no flags. The holding register is unaffected.
- frame_err and overrun are never both high. busy is combinational from state.

Test Plan (CLK_DIV=4 → 64 clk/bit):
- Send 0xA5 (8N1, 64 clk/bit) with data_ready=1 → data_valid high exactly 1 cycle, data_out=0xA5, frame_err=0, overrun=0, busy low after the stop sample.
- Drive irx low 20 clk then high (< 32-clk half bit) → busy pulses high, returns to IDLE, no data_valid/frame_err.
- Send 0x3C with stop bit forced 0 → frame_err single-cycle pulse at the stop sample, data_valid stays 0.
- data_ready=0, send 0x11 then 0x22 → data_out=0x11, data_valid=1, overrun pulse at the 0x22 stop sample. Then raise data_ready → data_valid clears next cycle, data_out remains 0x11.
- data_valid=1 with 0x11 and data_ready asserted exactly on the 0x22 stop-sample cycle → no overrun, data_out=0x22, data_valid stays 1.
- reset=0 for 1 clk during DATA bit 3 (and separately rx_enable=0 mid-frame) → all outputs 0 / IDLE, no flags. The following frame 0x5A is received correctly.
